// File: rtl/prbs_delay_scan_ctrl_if.sv
// prbs_delay_scan_ctrl_if: config, demod stream and status bundle for the delay scan controller.
// PRBS_SCAN_TRACE_EN adds the per-step trace signals.
interface prbs_delay_scan_ctrl_if #(
   parameter int DATA_W = 14, ACC_W = 40, DWELL_W = 24, SETTLE_W = 16
);
   logic start, abort;
   logic [31:0] cfg_delay_min, cfg_delay_max, cfg_delay_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [SETTLE_W-1:0] cfg_settle;
   logic signed [DATA_W-1:0] demod_tdata;
   logic demod_tvalid;
   logic [31:0] delay_out, best_delay;
   logic delay_load, busy, done, err;
   logic [ACC_W-1:0] best_mag;
`ifdef PRBS_SCAN_TRACE_EN
   logic trace_valid;
   logic [31:0] trace_delay;
   logic [ACC_W-1:0] trace_mag;
`endif
   modport master (
      output start, abort, cfg_delay_min, cfg_delay_max, cfg_delay_step, cfg_dwell, cfg_settle,
             demod_tdata, demod_tvalid,
      input delay_out, delay_load, busy, done, err, best_delay, best_mag
`ifdef PRBS_SCAN_TRACE_EN
      , input trace_valid, trace_delay, trace_mag
`endif
   );
   modport slave (
      input start, abort, cfg_delay_min, cfg_delay_max, cfg_delay_step, cfg_dwell, cfg_settle,
            demod_tdata, demod_tvalid,
      output delay_out, delay_load, busy, done, err, best_delay, best_mag
`ifdef PRBS_SCAN_TRACE_EN
      , output trace_valid, trace_delay, trace_mag
`endif
   );
endinterface

// File: rtl/prbs_delay_scan_ctrl.sv
// prbs_delay_scan_ctrl: steps the PRBS demod delay, integrates |sum| per step and loads the best delay.
// PRBS_SCAN_TRACE_EN adds trace_valid/trace_delay/trace_mag reporting every compared step.
module prbs_delay_scan_ctrl #(
   parameter int DATA_W = 14, ACC_W = 40, DWELL_W = 24, SETTLE_W = 16
) (
   input logic clk,
   input logic rst,
   prbs_delay_scan_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, ACCUM, CMP, FINISH} state_t;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   state_t state, state_n;
   logic [31:0] cur, max_s, step_s;
   logic [DWELL_W-1:0] dwell_s, cnt;
   logic [SETTLE_W-1:0] settle_s, scnt;
   logic signed [ACC_W-1:0] acc, acc_n;
   logic [ACC_W:0] sum;
   logic [ACC_W-1:0] mag;
   logic [32:0] nxt;
   logic first, accept, cfg_bad, kill, last_smp, last_step;
   always_comb begin
      kill = bus.abort && state != IDLE;
      accept = state == IDLE && bus.start && !bus.abort;
      cfg_bad = bus.cfg_delay_step == '0 || bus.cfg_delay_min > bus.cfg_delay_max;
      sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){bus.demod_tdata[DATA_W-1]}}, bus.demod_tdata};
      acc_n = sum[ACC_W] != sum[ACC_W-1] ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      mag = acc == ACC_MIN ? ACC_MAX : acc[ACC_W-1] ? -acc : acc;
      nxt = {1'b0, cur} + {1'b0, step_s};
      last_smp = bus.demod_tvalid && (cnt == dwell_s - DWELL_W'(1) || dwell_s == '0);
      last_step = nxt[32] || nxt[31:0] > max_s;
      state_n = state;
      case (state)
         IDLE: state_n = accept && !cfg_bad ? LOAD : IDLE;
         LOAD: state_n = settle_s == '0 ? ACCUM : SETTLE;
         SETTLE: state_n = scnt == settle_s - SETTLE_W'(1) ? ACCUM : SETTLE;
         ACCUM: state_n = last_smp ? CMP : ACCUM;
         CMP: state_n = last_step ? FINISH : LOAD;
         default: state_n = IDLE;
      endcase
      if (kill) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   assign bus.busy = state != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {cur, max_s, step_s, dwell_s, settle_s, cnt, scnt, acc, first} <= '0;
         {bus.delay_out, bus.delay_load, bus.done, bus.err, bus.best_delay, bus.best_mag} <= '0;
      end else begin
         bus.delay_load <= 1'b0;
         bus.done <= 1'b0;
         if (!kill)
            case (state)
               IDLE: if (accept) begin
                  max_s <= bus.cfg_delay_max;
                  step_s <= bus.cfg_delay_step;
                  dwell_s <= bus.cfg_dwell;
                  settle_s <= bus.cfg_settle;
                  cur <= bus.cfg_delay_min;
                  bus.best_delay <= '0;
                  bus.best_mag <= '0;
                  first <= 1'b1;
                  bus.err <= cfg_bad;
                  bus.done <= cfg_bad;
               end
               LOAD: begin
                  bus.delay_out <= cur;
                  bus.delay_load <= 1'b1;
                  acc <= '0;
                  cnt <= '0;
                  scnt <= '0;
               end
               SETTLE: scnt <= scnt + SETTLE_W'(1);
               ACCUM: if (bus.demod_tvalid) begin
                  acc <= acc_n;
                  cnt <= cnt + DWELL_W'(1);
               end
               CMP: begin
                  // strict compare keeps the earlier delay on ties
                  if (first || mag > bus.best_mag) begin
                     bus.best_mag <= mag;
                     bus.best_delay <= cur;
                  end
                  first <= 1'b0;
                  if (!last_step) cur <= nxt[31:0];
               end
               FINISH: begin
                  bus.delay_out <= bus.best_delay;
                  bus.delay_load <= 1'b1;
                  bus.done <= 1'b1;
               end
               default: ;
            endcase
      end
   end
`ifdef PRBS_SCAN_TRACE_EN
   assign bus.trace_valid = state == CMP;
   assign bus.trace_delay = cur;
   assign bus.trace_mag = mag;
`endif
endmodule

// File: tb/tb_prbs_delay_scan_ctrl.sv
// tb_prbs_delay_scan_ctrl: directed bench for the delay scan controller with a 16-bit accumulator.
module tb_prbs_delay_scan_ctrl;
   localparam int DATA_W = 14, ACC_W = 16, DWELL_W = 24, SETTLE_W = 16;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, errors = 0;
   int n_loads, n_dones, done_cycle;
   logic done_load;
   logic [31:0] done_delay, peak_a, peak_b;
   logic signed [DATA_W-1:0] peak_val, base_val;
   logic gap;
   prbs_delay_scan_ctrl_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DWELL_W(DWELL_W), .SETTLE_W(SETTLE_W)) bus ();
   prbs_delay_scan_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DWELL_W(DWELL_W), .SETTLE_W(SETTLE_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic cfg(input logic [31:0] mn, input logic [31:0] mx, input logic [31:0] st, input int dw, input int se);
      bus.cfg_delay_min = mn;
      bus.cfg_delay_max = mx;
      bus.cfg_delay_step = st;
      bus.cfg_dwell = dw[DWELL_W-1:0];
      bus.cfg_settle = se[SETTLE_W-1:0];
   endtask

   // demod model: peak value on the two peak delays, base value elsewhere
   task automatic drive_demod(input int n);
      bus.demod_tvalid = gap ? n[0] : 1'b1;
      bus.demod_tdata = (bus.delay_out == peak_a || bus.delay_out == peak_b) ? peak_val : base_val;
   endtask

   task automatic run_scan(input int poke_at);
      n_loads = 0; n_dones = 0; done_cycle = 0; done_load = 1'b0; done_delay = '0;
      drive_demod(0);
      bus.start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (n == 1 || n == poke_at + 1) bus.start = 1'b0;
         if (n == poke_at) begin
            bus.start = 1'b1;
            bus.cfg_delay_min = 32'd100;
            bus.cfg_delay_max = 32'd100;
         end
         if (bus.delay_load) n_loads++;
         if (bus.done) begin
            n_dones++;
            if (done_cycle == 0) begin done_cycle = n; done_load = bus.delay_load; done_delay = bus.delay_out; end
         end
         if (done_cycle != 0 && n >= done_cycle + 3) break;
         drive_demod(n);
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.abort = 1'b0; cfg(0, 0, 0, 0, 0);
      bus.demod_tvalid = 1'b0; bus.demod_tdata = '0;
      gap = 1'b0; peak_a = 32'hDEAD; peak_b = 32'hDEAD; peak_val = '0; base_val = 14'sd1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0 || bus.delay_load !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_strobes: got done=%b load=%b err=%b want 0", bus.done, bus.delay_load, bus.err); end
      checks++; if (bus.delay_out !== 32'd0 || bus.best_delay !== 32'd0 || bus.best_mag !== 16'd0) begin errors++; $display("FAIL reset_values: got out=%0d best=%0d mag=%0d want 0", bus.delay_out, bus.best_delay, bus.best_mag); end
      rst = 1'b0;
      cfg(5, 5, 1, 50, 1);
      bus.demod_tvalid = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.delay_out !== 32'd5) begin errors++; $display("FAIL mid_accum: got busy=%b out=%0d want 1/5", bus.busy, bus.delay_out); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.delay_out !== 32'd0 || bus.delay_load !== 1'b0) begin errors++; $display("FAIL async_reset: got busy=%b out=%0d load=%b want 0", bus.busy, bus.delay_out, bus.delay_load); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_peak_find;
      cfg(0, 10, 2, 8, 3);
      peak_a = 32'd6; peak_b = 32'd6; peak_val = 14'sd100; base_val = '0;
      run_scan(0);
      checks++; if (done_cycle !== 80) begin errors++; $display("FAIL peak_latency: got %0d want 80", done_cycle); end
      checks++; if (n_dones !== 1 || n_loads !== 7) begin errors++; $display("FAIL peak_strobes: got dones=%0d loads=%0d want 1/7", n_dones, n_loads); end
      checks++; if (done_load !== 1'b1 || done_delay !== 32'd6) begin errors++; $display("FAIL peak_final_load: got load=%b out=%0d want 1/6", done_load, done_delay); end
      checks++; if (bus.best_delay !== 32'd6 || bus.best_mag !== 16'd800) begin errors++; $display("FAIL peak_best: got %0d/%0d want 6/800", bus.best_delay, bus.best_mag); end
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL peak_end: got err=%b busy=%b want 0/0", bus.err, bus.busy); end
   endtask

   task automatic test_cfg_error;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) cfg(0, 10, 0, 4, 0);
         else cfg(5, 4, 1, 4, 0);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL cfg_err%0d: got done=%b err=%b want 1/1", k, bus.done, bus.err); end
         checks++; if (bus.delay_load !== 1'b0 || bus.busy !== 1'b0 || bus.delay_out !== 32'd6) begin errors++; $display("FAIL cfg_noload%0d: got load=%b busy=%b out=%0d want 0/0/6", k, bus.delay_load, bus.busy, bus.delay_out); end
         @(negedge clk);
         checks++; if (bus.done !== 1'b0 || bus.err !== 1'b1) begin errors++; $display("FAIL cfg_pulse%0d: got done=%b err=%b want 0/1", k, bus.done, bus.err); end
      end
   endtask

   task automatic test_wrap;
      cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 4, 0);
      peak_a = 32'hDEAD; peak_b = 32'hDEAD; peak_val = '0; base_val = 14'sd1;
      run_scan(0);
      checks++; if (done_cycle !== 8 || n_loads !== 2 || n_dones !== 1) begin errors++; $display("FAIL wrap_flow: got cyc=%0d loads=%0d dones=%0d want 8/2/1", done_cycle, n_loads, n_dones); end
      checks++; if (done_delay !== 32'hFFFF_FFF0 || bus.best_mag !== 16'd4) begin errors++; $display("FAIL wrap_best: got %h/%0d want fffffff0/4", done_delay, bus.best_mag); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wrap_err_clear: got %b want 0", bus.err); end
   endtask

   task automatic test_saturation_ties;
      cfg(0, 0, 1, 16, 0);
      base_val = 14'h2000;
      run_scan(0);
      checks++; if (bus.best_mag !== 16'd32767 || bus.best_delay !== 32'd0) begin errors++; $display("FAIL sat_mag: got %0d/%0d want 32767/0", bus.best_mag, bus.best_delay); end
      cfg(0, 4, 2, 4, 0);
      peak_a = 32'd2; peak_b = 32'd4; peak_val = 14'sd50; base_val = '0;
      run_scan(0);
      checks++; if (bus.best_delay !== 32'd2 || bus.best_mag !== 16'd200 || n_loads !== 4) begin errors++; $display("FAIL ties: got %0d/%0d loads=%0d want 2/200/4", bus.best_delay, bus.best_mag, n_loads); end
      cfg(8, 12, 2, 2, 0);
      peak_a = 32'hDEAD; peak_b = 32'hDEAD; base_val = '0;
      run_scan(0);
      checks++; if (bus.best_delay !== 32'd8 || done_delay !== 32'd8) begin errors++; $display("FAIL first_step: got %0d/%0d want 8/8", bus.best_delay, done_delay); end
   endtask

   task automatic test_gaps;
      cfg(3, 3, 1, 8, 2);
      gap = 1'b1; base_val = 14'sd7;
      run_scan(0);
      gap = 1'b0;
      checks++; if (done_cycle !== 22) begin errors++; $display("FAIL gap_latency: got %0d want 22", done_cycle); end
      checks++; if (bus.best_mag !== 16'd56 || bus.best_delay !== 32'd3) begin errors++; $display("FAIL gap_best: got %0d/%0d want 56/3", bus.best_mag, bus.best_delay); end
   endtask

   task automatic test_abort;
      cfg(20, 40, 10, 4, 10);
      base_val = 14'sd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.delay_out !== 32'd20) begin errors++; $display("FAIL abort_idle: got busy=%b out=%0d want 0/20", bus.busy, bus.delay_out); end
      checks++; if (bus.best_mag !== 16'd0 || bus.best_delay !== 32'd0) begin errors++; $display("FAIL abort_best: got %0d/%0d want 0/0", bus.best_mag, bus.best_delay); end
      n_dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) n_dones++;
      end
      checks++; if (n_dones !== 0) begin errors++; $display("FAIL abort_nodone: got %0d want 0", n_dones); end
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_priority: got busy=%b want 0", bus.busy); end
   endtask

   task automatic test_start_busy;
      cfg(0, 0, 1, 4, 5);
      base_val = 14'sd3;
      run_scan(3);
      checks++; if (done_cycle !== 13 || n_dones !== 1 || n_loads !== 2) begin errors++; $display("FAIL busy_start_flow: got cyc=%0d dones=%0d loads=%0d want 13/1/2", done_cycle, n_dones, n_loads); end
      checks++; if (bus.best_delay !== 32'd0 || bus.best_mag !== 16'd12 || done_delay !== 32'd0) begin errors++; $display("FAIL busy_start_best: got %0d/%0d/%0d want 0/12/0", bus.best_delay, bus.best_mag, done_delay); end
   endtask

   initial begin
      test_reset();
      test_peak_find();
      test_cfg_error();
      test_wrap();
      test_saturation_ties();
      test_gaps();
      test_abort();
      test_start_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
